pe_cfg_streamer: RTL and testbench
==================================

// Module: pe_cfg_streamer
// PURPOSE
//  Transmit side of the PE configuration port. Walks a configuration image in a word memory
//  and drives each PE's 33-bit PE_Configure_Inport with {valid, word32}, one word per cycle.
//  Sits between the array's config memory and the PE_top instances; replaces hand-driven config.
// PARAMETERS
//  NUM_PE   2   number of PE config ports driven (pe_id range 0..NUM_PE-1)
//  ADDR_W   10  config memory address width
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-low reset
//  start        in   1           pulse: begin loading image at base_addr (ignored while busy)
//  base_addr    in   ADDR_W      address of first descriptor
//  mem_rd_en    out  1           memory read strobe
//  mem_addr     out  ADDR_W      memory read address
//  mem_rd_data  in   32          read data, valid exactly 1 cycle after mem_rd_en
//  cfg_out      out  NUM_PE*33   PE n port = cfg_out[n*33 +: 33] = {valid, word}
//  busy         out  1           high from cycle after accepted start until done
//  done         out  1           1-cycle pulse at end of image (normal or abort)
//  err          out  1           sticky error; cleared by next accepted start
// BEHAVIOUR
//  - Reset: cfg_out=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, err=0, FSM=IDLE.
//  - Image: records {descriptor, len payload words}. Descriptor: [15:8] pe_id, [7:0] len.
//    len=0 is the terminator. Payload word 0 is the PE header word, the rest are operands.
//  - FSM: IDLE -start-> DESC_RD (issue read) -> DESC_WAIT (decode) -> STREAM (len words)
//    -> DESC_RD ... ; terminator -> FIN (done pulse) -> IDLE.
//  - STREAM issues reads on consecutive cycles. Each returned word is registered onto its PE
//    port with valid=1 for exactly one cycle. Consecutive payload words are contiguous.
//    All other ports, and idle cycles, drive 33'd0.
//  - Latency: start@T -> descriptor read@T+1 -> first payload read@T+3 -> cfg_out valid@T+4.
//    There is a 2-cycle gap (valid=0) between records.
//  - mem_addr increments by 1 per read and wraps modulo 2^ADDR_W.
//  - pe_id >= NUM_PE: set err, drive nothing, go to FIN (abort). Done still pulses.
//  - start while busy: ignored. start on the same cycle as done: ignored. Start is accepted from IDLE only.
//  - Reset asserted mid-stream: all outputs to 0 immediately (async); no partial word is held.
// CONFIGURATION
//  CFG_CHECKSUM_EN defined:
//  - Each record carries one extra word after the payload: the XOR of its len payload words.
//  - That word is read but not forwarded.
//  - Mismatch: set err and abort to FIN. Words already forwarded are not recalled.
//  CFG_CHECKSUM_EN undefined: no checksum word is present; err arises only from a bad pe_id.
// STRUCTURE
//  Shared package (pe_cfg_pkg):
//  - CFG_W=33, DATA_W=32
//  - descriptor field positions: PEID_LSB=8, LEN_LSB=0
//  - FSM state typedef
//  Optional sub-module pe_cfg_demux: registered one-hot fan-out of a {valid, word} to NUM_PE
//  ports. It holds the per-port output registers; the FSM, address counter and checksum
//  stay in the top.
// TESTING
//  1. Image @0: {pe0,len3: H0,0,5}, {pe1,len2: H1,2}, term; start
//     -> PE0 H0,0,5 on 3 consecutive cycles from T+4; PE1 H1,2 after a 2-cycle gap;
//     one done pulse; err=0.
//  2. Descriptor pe_id=7 with NUM_PE=2 -> no cfg_out valid, err=1, done pulses, busy falls.
//  3. base_addr=2^ADDR_W-2, record len=3 -> mem_addr sequence wraps ...,1023,0,1; data intact.
//  4. Reset deasserted then reasserted during STREAM word 2 of 4 -> cfg_out=0 at once;
//     after release and a new start, the full image replays.
//  5. start pulsed again while busy -> ignored; output identical to a single start; one done.
//  6. CFG_CHECKSUM_EN: good XOR -> no err; corrupt checksum on record 1 -> record 1 forwarded,
//     err=1, record 2 never driven.

Source files
------------

// File: rtl/pe_cfg_pkg.sv
// Shared types and constants for the PE configuration streamer.
//   CFG_W/DATA_W : width of one PE config port ({valid, word}) and of a config word
//   PEID_*/LEN_* : descriptor field positions and widths
//   state_e      : streamer FSM states
//   cfg_word_t   : {valid, word} payload presented to a PE config port
package pe_cfg_pkg;

  localparam int unsigned CFG_W    = 33;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned PEID_LSB = 8;
  localparam int unsigned PEID_W   = 8;
  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned LEN_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DESC_RD,
    ST_DESC_WAIT,
    ST_STREAM,
    ST_CHK_RD,
    ST_CHK_WAIT,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] word;
  } cfg_word_t;

endpackage

// File: rtl/pe_cfg_streamer_demux.sv
// Registered one-hot fan-out of a {valid, word} onto NUM_PE config ports.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   cfg_word   : {valid, word} to forward this cycle
//   sel        : destination PE index
//   cfg_out    : port n = cfg_out[n*CFG_W +: CFG_W]; unselected ports drive zero
module pe_cfg_demux
  import pe_cfg_pkg::*;
#(
  parameter int unsigned NUM_PE = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  cfg_word_t               cfg_word,
  input  logic [SEL_W-1:0]        sel,
  output logic [NUM_PE*CFG_W-1:0] cfg_out
);

  // Each port carries the word for exactly one cycle, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_out <= '0;
    end else begin
      for (int unsigned n = 0; n < NUM_PE; n++) begin
        if (cfg_word.vld && (sel == SEL_W'(n))) begin
          cfg_out[n*CFG_W +: CFG_W] <= cfg_word;
        end else begin
          cfg_out[n*CFG_W +: CFG_W] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/pe_cfg_streamer.sv
// Walks a configuration image in word memory and streams each record's payload
// onto the addressed PE config port, one word per cycle.
// Image: {descriptor([15:8] pe_id, [7:0] len), len payload words}...; len=0 terminates.
// Optional feature macro CFG_CHECKSUM_EN: each record is followed by an XOR checksum
// word of its payload; the word is read, not forwarded, and a mismatch aborts with err.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   start       : begin loading at base_addr (accepted from idle only)
//   base_addr   : address of first descriptor
//   mem_rd_en   : memory read strobe; mem_rd_data valid one cycle later
//   mem_addr    : memory read address (wraps modulo 2^ADDR_W)
//   mem_rd_data : memory read data
//   cfg_out     : PE n port = cfg_out[n*33 +: 33] = {valid, word}
//   busy        : high from the cycle after an accepted start through done
//   done        : one-cycle pulse at end of image (normal or abort)
//   err         : sticky error, cleared by the next accepted start
module pe_cfg_streamer
  import pe_cfg_pkg::*;
#(
  parameter int unsigned NUM_PE = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rd_data,
  output logic [NUM_PE*CFG_W-1:0] cfg_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  state_e             state_q, state_d;
  logic               rd_en_d, busy_d, done_d, err_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [PE_W-1:0]    pe_q, pe_d;
  logic               fwd_q;
  logic [PEID_W-1:0]  desc_pe;
  logic [LEN_W-1:0]   desc_len;
  cfg_word_t          fwd_word;

  assign desc_pe  = mem_rd_data[PEID_LSB +: PEID_W];
  assign desc_len = mem_rd_data[LEN_LSB +: LEN_W];

  // Running XOR of the current record's forwarded payload.
`ifdef CFG_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xor_q <= '0;
    end else if (state_q == ST_DESC_WAIT) begin
      xor_q <= '0;
    end else if (fwd_q) begin
      xor_q <= xor_q ^ mem_rd_data;
    end
  end
`endif

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    rd_en_d = 1'b0;
    addr_d  = mem_addr;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = err;
    cnt_d   = cnt_q;
    pe_d    = pe_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DESC_RD;
          rd_en_d = 1'b1;
          addr_d  = base_addr;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_DESC_RD: begin
        state_d = ST_DESC_WAIT;
      end
      ST_DESC_WAIT: begin
        if (desc_len == '0) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end else if (32'(desc_pe) >= NUM_PE) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_STREAM;
          rd_en_d = 1'b1;
          addr_d  = mem_addr + ADDR_W'(1);
          cnt_d   = desc_len;
          pe_d    = PE_W'(desc_pe);
        end
      end
      ST_STREAM: begin
        // The next read (payload, checksum or descriptor) always follows back-to-back.
        rd_en_d = 1'b1;
        addr_d  = mem_addr + ADDR_W'(1);
        if (cnt_q == LEN_W'(1)) begin
`ifdef CFG_CHECKSUM_EN
          state_d = ST_CHK_RD;
`else
          state_d = ST_DESC_RD;
`endif
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
`ifdef CFG_CHECKSUM_EN
      ST_CHK_RD: begin
        state_d = ST_CHK_WAIT;
      end
      ST_CHK_WAIT: begin
        if (mem_rd_data != xor_q) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_DESC_RD;
          rd_en_d = 1'b1;
          addr_d  = mem_addr + ADDR_W'(1);
        end
      end
`endif
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. fwd_q marks that the word arriving next cycle is payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_q     <= '0;
      pe_q      <= '0;
      fwd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_rd_en <= rd_en_d;
      mem_addr  <= addr_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cnt_q     <= cnt_d;
      pe_q      <= pe_d;
      fwd_q     <= (state_q == ST_STREAM);
    end
  end

  assign fwd_word.vld  = fwd_q;
  assign fwd_word.word = mem_rd_data;

  pe_cfg_demux #(
    .NUM_PE (NUM_PE),
    .SEL_W  (PE_W)
  ) u_demux (
    .clk      (clk),
    .reset    (reset),
    .cfg_word (fwd_word),
    .sel      (pe_q),
    .cfg_out  (cfg_out)
  );

endmodule

// File: tb/tb_pe_cfg_streamer.sv
// Self-checking bench for pe_cfg_streamer: builds images in a word memory model and
// checks cfg_out/done/busy/err cycle by cycle and the read address sequence against
// a schedule computed from the image layout.
module tb_pe_cfg_streamer;

  localparam int unsigned NUM_PE = 2;
  localparam int unsigned ADDR_W = 10;
  localparam int          DEPTH  = 1024;
  localparam int          CW     = 33;
  localparam int          MAXC   = 256;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [ADDR_W-1:0]      base_addr = '0;
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [31:0]            mem_rd_data = '0;
  logic [NUM_PE*CW-1:0]   cfg_out;
  logic                   busy, done, err;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0]          mem [DEPTH];
  int                   rd_log[$];
  int                   exp_addr[$];
  logic [NUM_PE*CW-1:0] exp_cfg [MAXC];
  int                   exp_done;
  logic                 exp_err;
  int                   wp;
  logic [31:0]          pay[$];

  always #5 clk = ~clk;

  pe_cfg_streamer #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .cfg_out     (cfg_out),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Memory: data for a read strobe sampled at an edge appears right after that edge.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      rd_log.push_back(int'(mem_addr));
    end
  end

  // Append one record at wp; payload from pay queue, else random.
  task automatic add_rec(input int pe, input int len, input bit corrupt);
    logic [31:0] w;
    logic [31:0] x;
    x = '0;
    mem[wp % DEPTH] = {16'd0, 8'(pe), 8'(len)};
    wp++;
    for (int i = 0; i < len; i++) begin
      if (pay.size() > 0) w = pay.pop_front();
      else w = $urandom();
      mem[wp % DEPTH] = w;
      x = x ^ w;
      wp++;
    end
`ifdef CFG_CHECKSUM_EN
    mem[wp % DEPTH] = corrupt ? ~x : x;
    wp++;
`else
    if (corrupt) x = ~x;
`endif
    pay.delete();
  endtask

  task automatic add_term();
    mem[wp % DEPTH] = '0;
    wp++;
  endtask

  // Reference schedule: descriptor decoded at cycle d (first one at 2 after start);
  // its payload appears at d+2.., next descriptor decodes len+2 cycles later
  // (len+4 with a checksum word); done is seen on the cycle the ending decision is made.
  task automatic build_model(input int base);
    int a, d, pe, len;
    logic [31:0] desc, w;
    bit fin;
`ifdef CFG_CHECKSUM_EN
    logic [31:0] x;
`endif
    for (int c = 0; c < MAXC; c++) exp_cfg[c] = '0;
    exp_addr.delete();
    exp_err = 1'b0;
    a = base;
    d = 2;
    fin = 0;
    while (!fin) begin
      desc = mem[a % DEPTH];
      exp_addr.push_back(a % DEPTH);
      pe  = int'(desc[15:8]);
      len = int'(desc[7:0]);
      if (len == 0) begin
        exp_done = d;
        fin = 1;
      end else if (pe >= int'(NUM_PE)) begin
        exp_err = 1'b1;
        exp_done = d;
        fin = 1;
      end else begin
`ifdef CFG_CHECKSUM_EN
        x = '0;
`endif
        for (int i = 0; i < len; i++) begin
          w = mem[(a + 1 + i) % DEPTH];
          exp_addr.push_back((a + 1 + i) % DEPTH);
          exp_cfg[d + 2 + i][pe*CW +: CW] = {1'b1, w};
`ifdef CFG_CHECKSUM_EN
          x = x ^ w;
`endif
        end
`ifdef CFG_CHECKSUM_EN
        exp_addr.push_back((a + 1 + len) % DEPTH);
        if (mem[(a + 1 + len) % DEPTH] !== x) begin
          exp_err = 1'b1;
          exp_done = d + len + 2;
          fin = 1;
        end else begin
          d += len + 4;
          a += len + 2;
        end
`else
        d += len + 2;
        a += len + 1;
`endif
      end
    end
  endtask

  // Start one image and check every cycle until a few cycles past done.
  task automatic run_image(input string name, input int base, input bit dup);
    logic exp_e;
    build_model(base);
    rd_log.delete();
    @(negedge clk);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(posedge clk);
      #1;
      start = dup && (c == 2 || c == exp_done);
      if (start) base_addr = ADDR_W'($urandom());
      exp_e = (c >= exp_done) ? exp_err : 1'b0;
      n_chk++;
      if (cfg_out !== exp_cfg[c]) begin
        n_bad++;
        $display("FAIL %s cfg_out c=%0d got=%h want=%h", name, c, cfg_out, exp_cfg[c]);
      end
      n_chk++;
      if (done !== (c == exp_done)) begin
        n_bad++;
        $display("FAIL %s done c=%0d got=%b want=%b", name, c, done, (c == exp_done));
      end
      n_chk++;
      if (busy !== (c <= exp_done)) begin
        n_bad++;
        $display("FAIL %s busy c=%0d got=%b want=%b", name, c, busy, (c <= exp_done));
      end
      n_chk++;
      if (err !== exp_e) begin
        n_bad++;
        $display("FAIL %s err c=%0d got=%b want=%b", name, c, err, exp_e);
      end
    end
    start = 1'b0;
    n_chk++;
    if (rd_log.size() != exp_addr.size()) begin
      n_bad++;
      $display("FAIL %s read_count got=%0d want=%0d", name, rd_log.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < rd_log.size(); i++) begin
        n_chk++;
        if (rd_log[i] != exp_addr[i]) begin
          n_bad++;
          $display("FAIL %s read_addr[%0d] got=%0d want=%0d", name, i, rd_log[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (cfg_out !== '0)   begin n_bad++; $display("FAIL reset cfg_out got=%h want=0", cfg_out); end
    n_chk++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset mem_rd_en got=%b want=0", mem_rd_en); end
    n_chk++; if (mem_addr !== '0)  begin n_bad++; $display("FAIL reset mem_addr got=%0d want=0", mem_addr); end
    n_chk++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset busy got=%b want=0", busy); end
    n_chk++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset done got=%b want=0", done); end
    n_chk++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset err got=%b want=0", err); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] h0, h1;
    h0 = $urandom();
    h1 = $urandom();
    wp = 0;
    pay = '{h0, 32'd0, 32'd5};
    add_rec(0, 3, 1'b0);
    pay = '{h1, 32'd2};
    add_rec(1, 2, 1'b0);
    add_term();
    run_image("basic", 0, 1'b0);
  endtask

  task automatic test_bad_pe();
    wp = 32;
    add_rec(7, 3, 1'b0);
    add_term();
    run_image("bad_pe", 32, 1'b0);
  endtask

  task automatic test_wrap();
    wp = DEPTH - 2;
    add_rec(1, 3, 1'b0);
    add_term();
    run_image("wrap", DEPTH - 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] want;
    wp = 100;
    add_rec(0, 4, 1'b0);
    add_term();
    want = {1'b1, mem[102]};
    @(negedge clk);
    base_addr = ADDR_W'(100);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (cfg_out[CW-1:0] !== want) begin
      n_bad++;
      $display("FAIL reset_mid word2 got=%h want=%h", cfg_out[CW-1:0], want);
    end
    #1;
    reset = 1'b0;
    #1;
    n_chk++; if (cfg_out !== '0)     begin n_bad++; $display("FAIL reset_mid cfg_out got=%h want=0", cfg_out); end
    n_chk++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_mid busy got=%b want=0", busy); end
    n_chk++; if (mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_mid mem_rd_en got=%b want=0", mem_rd_en); end
    n_chk++; if (mem_addr !== '0)    begin n_bad++; $display("FAIL reset_mid mem_addr got=%0d want=0", mem_addr); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_image("replay", 100, 1'b0);
  endtask

  task automatic test_dup_start();
    wp = 200;
    add_rec(1, 2, 1'b0);
    add_rec(0, 3, 1'b0);
    add_term();
    run_image("dup_start", 200, 1'b1);
  endtask

  task automatic test_random();
    int base, nrec, pe, len;
    bit bad;
    for (int it = 0; it < 8; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      wp = base;
      nrec = $urandom_range(1, 4);
      for (int r = 0; r < nrec; r++) begin
        pe  = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 255) : $urandom_range(0, 1);
        len = $urandom_range(1, 6);
`ifdef CFG_CHECKSUM_EN
        bad = ($urandom_range(0, 7) == 0);
`else
        bad = 1'b0;
`endif
        add_rec(pe, len, bad);
      end
      add_term();
      run_image("random", base, it[0]);
    end
  endtask

`ifdef CFG_CHECKSUM_EN
  task automatic test_checksum();
    wp = 400;
    add_rec(1, 2, 1'b0);
    add_rec(0, 1, 1'b0);
    add_term();
    run_image("chk_good", 400, 1'b0);
    wp = 450;
    add_rec(0, 3, 1'b1);
    add_rec(1, 2, 1'b0);
    add_term();
    run_image("chk_bad", 450, 1'b0);
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_bad_pe();
    test_wrap();
    test_reset_mid();
    test_dup_start();
`ifdef CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
